vga_sprite_ram_writer: RTL

//   Write-side front end for the dual-use sprite RAM. Buffers sprite update requests from
//   the game logic in a small FIFO and issues them to the RAM write port only while the

---
 rtl/vga_sprite_ram_writer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vga_sprite_ram_writer.sv
// vga_sprite_ram_writer
//   Write-side front end for the sprite RAM. Sprite fill requests are queued in a
//   small FIFO and replayed to the RAM write port only while the display is blanking,
//   so active-video sprite fetches never see a write cycle.
//   Each request writes one data word to count+1 consecutive addresses (wrapping).
//   Optional feature macro: SPRITE_WR_COUNT_EN adds a saturating 16-bit write counter
//   output (wr_count). Without the macro the port and counter do not exist.
//
//   state | meaning
//   IDLE  | no burst in progress; pops the FIFO head when one is queued
//   WRITE | burst loaded; one word per cycle while blank is high, holds otherwise
module vga_sprite_ram_writer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_data,
  input  logic [ADDRESS_WIDTH-1:0] req_count,
  input  logic                     blank,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_data,
  output logic                     busy,
  output logic                     done
`ifdef SPRITE_WR_COUNT_EN
  ,
  output logic [15:0]              wr_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state, next_state;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW:0] wr_ptr, rd_ptr;
  logic [ADDRESS_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data  [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_count [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, pop;
  logic load, advance, finish;
  logic [ADDRESS_WIDTH-1:0] remaining;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && req_ready;
  assign ram_wEn    = (state == WRITE) && blank;
  assign busy       = (state != IDLE) || !fifo_empty;

  // FIFO pointer update; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]]  <= req_addr;
      fifo_data[wr_ptr[PW-1:0]]  <= req_data;
      fifo_count[wr_ptr[PW-1:0]] <= req_count;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and datapath control.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (blank) begin
          if (remaining != '0) begin
            advance = 1'b1;
          end else begin
            finish     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Burst address/data/remaining registers and the done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_addr  <= '0;
      ram_data  <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        ram_addr  <= fifo_addr[rd_ptr[PW-1:0]];
        ram_data  <= fifo_data[rd_ptr[PW-1:0]];
        remaining <= fifo_count[rd_ptr[PW-1:0]];
      end else if (advance) begin
        ram_addr  <= ram_addr + ADDR_ONE;
        remaining <= remaining - ADDR_ONE;
      end
    end
  end

`ifdef SPRITE_WR_COUNT_EN
  // Saturating count of issued RAM writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_count <= '0;
    else if (ram_wEn && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
  end
`endif

endmodule
